hawk_request_scheduler: RTL and testbench
=========================================

Name: hawk_request_scheduler

Overview:
- Front-end scheduler for the HAWK light controller.
- Merges N crosswalk pushbuttons into one latched pedestrian request and issues it to the controller's YP input with a level handshake.
- Enforces a minimum vehicle right-of-way hold-off between pedestrian cycles.
- Provides the controller's step timebase (tick) and the walk-interval counter that drives the controller's count input from its clr_count/inc_count outputs.

Parameters:
- N_BTN, 2, number of pushbutton inputs (1..8)
- TICK_DIV, 50000000, clk cycles per controller step tick (>=2)
- MIN_GO_TICKS, 10, ticks of vehicle hold-off after a pedestrian cycle ends (0 allowed)
- WALK_TICKS, 7, inc_count ticks before count asserts (>=1)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- btn  in  N_BTN  raw pushbuttons, asynchronous, active-high
- clr_count  in  1  from controller; high only while controller is idle; also clears walk counter
- inc_count  in  1  from controller; walk interval running
- tick  out  1  one-clk step strobe for the controller
- yp  out  1  pedestrian request to controller (level)
- count  out  1  walk interval complete
- btn_ack  out  N_BTN  per-button "request registered" lamp
- req_pending  out  1  a request is latched but not yet granted
- lockout  out  1  vehicle hold-off active

Behaviour:
- Reset values: tick=0, yp=0, count=0, btn_ack=0, req_pending=0, lockout=0. Internal state: state=READY, tick counter=0, walk counter=0, hold-off counter=0, synchronisers=0.
- Timebase:
  - tick_cnt runs 0..TICK_DIV-1 and wraps.
  - tick=1 for exactly one clk when tick_cnt==TICK_DIV-1, i.e. every TICK_DIV clks, free-running from reset.
- Button path:
  - Each btn bit passes a 2-FF synchroniser, then rising-edge detect.
  - Edge-to-press latency is 3 clks.
  - A held button produces one press only.
- Walk counter (updates only on tick):
  - If clr_count, walk_cnt<=0.
  - Else if inc_count and walk_cnt<WALK_TICKS, walk_cnt+1; it saturates at WALK_TICKS.
  - clr_count has priority over inc_count.
  - count = (walk_cnt==WALK_TICKS), registered-derived, so it is stable between ticks.
- Scheduler FSM, states READY, GRANT, SERVE, HOLDOFF:
  - READY:
    - Any press: set btn_ack[i] for each pressing button, set req_pending, go to GRANT.
  - GRANT:
    - yp=1.
    - Further presses still set their btn_ack bits.
    - When clr_count==0 (controller has left idle): clear btn_ack and req_pending, go to SERVE.
    - yp is held across as many ticks as needed; no timeout.
  - SERVE:
    - yp=0.
    - Presses are ignored: no btn_ack, no pending.
    - When clr_count returns to 1: load holdoff_cnt=MIN_GO_TICKS, go to HOLDOFF.
  - HOLDOFF:
    - lockout=1.
    - Presses set btn_ack[i] and req_pending.
    - holdoff_cnt decrements on each tick.
    - When holdoff_cnt==0: go to GRANT if req_pending (or a press this clk), else READY.
    - With MIN_GO_TICKS=0, HOLDOFF lasts exactly 1 clk.
- Output timing:
  - yp, lockout and req_pending are registered from state, so they change 1 clk after the transition condition.
  - btn_ack bits are registered.
- Simultaneous events:
  - A press in the same clk as the HOLDOFF expiry is granted; it is not lost.
  - Presses on several buttons in the same clk set all corresponding btn_ack bits.
- Reset asserted mid-operation: immediate return to all reset values; any latched requests are discarded.
- Width rules:
  - Counter widths are $clog2(param+1).
  - No counter ever wraps except tick_cnt.

Test Plan:
1. Params TICK_DIV=4, MIN_GO_TICKS=3, WALK_TICKS=5. After reset release, tick pulses at clk 4, 8, 12; yp=0, count=0, all outputs 0.
2. btn=2'b01 pulse while READY, clr_count=1 -> btn_ack=01 and req_pending=1, yp=1 within 4 clks. Drop clr_count -> next clk yp=0, btn_ack=00, state SERVE.
3. clr_count=0, inc_count=1 for 5 ticks -> count=1 after the 5th tick. It stays 1 on a 6th tick (saturation). clr_count=1 with inc_count=1 on the next tick -> count=0.
4. In SERVE press btn[1] -> btn_ack stays 00. Raise clr_count -> lockout=1. Press btn[1] during hold-off -> btn_ack=10, yp stays 0. After 3 ticks yp=1, lockout=0.
5. No press during hold-off -> after 3 ticks state READY, yp=0. Press arriving on the exact expiry clk -> yp=1.
6. Reset pulse while in GRANT with btn_ack=11 -> all outputs 0 immediately, tick_cnt restarts (next tick 4 clks after release).

Source files
------------

// File: rtl/hawk_request_scheduler.sv
// HAWK front-end: pushbutton request latch and grant handshake, vehicle hold-off,
// controller step timebase and walk-interval counter.
module hawk_request_scheduler #(
  parameter int N_BTN        = 2,
  parameter int TICK_DIV     = 50000000,
  parameter int MIN_GO_TICKS = 10,
  parameter int WALK_TICKS   = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic             clr_count,
  input  logic             inc_count,
  output logic             tick,
  output logic             yp,
  output logic             count,
  output logic [N_BTN-1:0] btn_ack,
  output logic             req_pending,
  output logic             lockout
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int HW = (MIN_GO_TICKS > 0) ? $clog2(MIN_GO_TICKS + 1) : 1;
  localparam int WW = $clog2(WALK_TICKS + 1);

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0] HOLD_LOAD  = HW'(MIN_GO_TICKS);
  localparam logic [WW-1:0] WALK_LIMIT = WW'(WALK_TICKS);

  typedef enum logic [1:0] {READY, GRANT, SERVE, HOLDOFF} state_t;

  state_t           state, next_state;
  logic [TW-1:0]    tick_cnt;
  logic [WW-1:0]    walk_cnt;
  logic [HW-1:0]    holdoff_cnt, holdoff_next;
  logic [N_BTN-1:0] sync1, sync2, sync3, press;
  logic [N_BTN-1:0] ack_next;
  logic             pend_next;
  logic             any_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) tick_cnt <= '0;
    else if (tick_cnt == TICK_LAST) tick_cnt <= '0;
    else tick_cnt <= tick_cnt + 1'b1;
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Two synchroniser stages, a history stage and a registered rising-edge strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      press <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync2 & ~sync3;
    end
  end

  assign any_press = |press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) walk_cnt <= '0;
    else if (tick) begin
      if (clr_count) walk_cnt <= '0;
      else if (inc_count && (walk_cnt < WALK_LIMIT)) walk_cnt <= walk_cnt + 1'b1;
    end
  end

  assign count = (walk_cnt == WALK_LIMIT);

  always_comb begin
    next_state   = state;
    ack_next     = btn_ack;
    pend_next    = req_pending;
    holdoff_next = holdoff_cnt;
    case (state)
      READY: begin
        if (any_press) begin
          ack_next   = btn_ack | press;
          pend_next  = 1'b1;
          next_state = GRANT;
        end
      end
      GRANT: begin
        ack_next = btn_ack | press;
        if (!clr_count) begin
          ack_next   = '0;
          pend_next  = 1'b0;
          next_state = SERVE;
        end
      end
      SERVE: begin
        if (clr_count) begin
          holdoff_next = HOLD_LOAD;
          next_state   = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (any_press) begin
          ack_next  = btn_ack | press;
          pend_next = 1'b1;
        end
        // Expiry takes priority over a tick; a press on the expiry clk still grants.
        if (holdoff_cnt == '0) next_state = (req_pending || any_press) ? GRANT : READY;
        else if (tick) holdoff_next = holdoff_cnt - 1'b1;
      end
      default: next_state = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= READY;
      btn_ack     <= '0;
      req_pending <= 1'b0;
      holdoff_cnt <= '0;
      yp          <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      state       <= next_state;
      btn_ack     <= ack_next;
      req_pending <= pend_next;
      holdoff_cnt <= holdoff_next;
      yp          <= (next_state == GRANT);
      lockout     <= (next_state == HOLDOFF);
    end
  end

endmodule

// File: tb/tb_hawk_request_scheduler.sv
// Self-checking bench for hawk_request_scheduler with a small timebase so
// hold-off and walk intervals complete in a few dozen clocks.
module tb_hawk_request_scheduler;

  localparam int N_BTN    = 2;
  localparam int TICK_DIV = 4;
  localparam int MIN_GO   = 3;
  localparam int WALK     = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [N_BTN-1:0] btn;
  logic             clr_count;
  logic             inc_count;
  logic             tick;
  logic             yp;
  logic             count;
  logic [N_BTN-1:0] btn_ack;
  logic             req_pending;
  logic             lockout;

  int errors = 0;
  int checks = 0;
  logic exp_q[$];

  typedef struct {
    logic clr;
    logic inc;
    logic exp_count;
  } walk_vec_t;

  walk_vec_t walk_tbl[8];

  hawk_request_scheduler #(
    .N_BTN(N_BTN),
    .TICK_DIV(TICK_DIV),
    .MIN_GO_TICKS(MIN_GO),
    .WALK_TICKS(WALK)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn(btn),
    .clr_count(clr_count),
    .inc_count(inc_count),
    .tick(tick),
    .yp(yp),
    .count(count),
    .btn_ack(btn_ack),
    .req_pending(req_pending),
    .lockout(lockout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_yp"}, {7'd0, yp}, 8'd0);
    checkOutput({tag, "_ack"}, {6'd0, btn_ack}, 8'd0);
    checkOutput({tag, "_pend"}, {7'd0, req_pending}, 8'd0);
    checkOutput({tag, "_lockout"}, {7'd0, lockout}, 8'd0);
    checkOutput({tag, "_count"}, {7'd0, count}, 8'd0);
    checkOutput({tag, "_tick"}, {7'd0, tick}, 8'd0);
  endtask

  // Tick phase k clks after reset release: high when k mod TICK_DIV == TICK_DIV-1.
  task automatic checkTicks(input int cycles, input string name);
    for (int k = 1; k <= cycles; k++) begin
      exp_q.push_back((k % TICK_DIV) == (TICK_DIV - 1));
      @(negedge clk);
      checkOutput(name, {7'd0, tick}, {7'd0, exp_q.pop_front()});
    end
  endtask

  task automatic waitTick();
    int n = 0;
    while (tick !== 1'b1 && n < 3 * TICK_DIV) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tick_wait", {7'd0, tick}, 8'd1);
  endtask

  task automatic waitYp(input int bound);
    int n = 0;
    while (yp !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("yp_wait", {7'd0, yp}, 8'd1);
  endtask

  task automatic pressButtons(input logic [N_BTN-1:0] mask, input int settle);
    btn = mask;
    repeat (3) @(negedge clk);
    btn = '0;
    repeat (settle) @(negedge clk);
  endtask

  task automatic applyStimulus(input walk_vec_t v);
    waitTick();
    clr_count = v.clr;
    inc_count = v.inc;
    exp_q.push_back(v.exp_count);
    @(negedge clk);
    checkOutput("walk_count", {7'd0, count}, {7'd0, exp_q.pop_front()});
  endtask

  // Enter hold-off on a tick edge, then clr_count=1 from the tick-observed negedge.
  task automatic enterHoldoff();
    waitTick();
    clr_count = 1'b1;
    @(negedge clk);
  endtask

  // n counts clks after hold-off entry; expiry lands on clk 13 with MIN_GO=3, TICK_DIV=4.
  task automatic runHoldoff(input logic [N_BTN-1:0] mask, input int press_at, input logic want_grant);
    checkOutput("hold_lockout_on", {7'd0, lockout}, 8'd1);
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      if (mask != '0 && n == press_at) btn = mask;
      if (n == press_at + 3) btn = '0;
      if (mask != '0 && n == press_at + 4) checkOutput("hold_ack", {6'd0, btn_ack}, {6'd0, mask});
      if (n == 12) begin
        checkOutput("hold_lockout_late", {7'd0, lockout}, 8'd1);
        checkOutput("hold_yp_late", {7'd0, yp}, 8'd0);
      end
      if (n == 13) begin
        checkOutput("hold_lockout_end", {7'd0, lockout}, 8'd0);
        checkOutput("hold_yp_end", {7'd0, yp}, {7'd0, want_grant});
      end
    end
  endtask

  initial begin
    walk_tbl[0] = '{1'b0, 1'b1, 1'b0};
    walk_tbl[1] = '{1'b0, 1'b1, 1'b0};
    walk_tbl[2] = '{1'b0, 1'b1, 1'b0};
    walk_tbl[3] = '{1'b0, 1'b1, 1'b0};
    walk_tbl[4] = '{1'b0, 1'b1, 1'b1};
    walk_tbl[5] = '{1'b0, 1'b1, 1'b1};
    walk_tbl[6] = '{1'b0, 1'b0, 1'b1};
    walk_tbl[7] = '{1'b1, 1'b1, 1'b0};

    reset     = 1'b1;
    btn       = '0;
    clr_count = 1'b1;
    inc_count = 1'b0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    reset = 1'b0;
    checkTicks(12, "tick_phase");

    // Request from READY, then the controller leaves idle.
    btn = 2'b01;
    repeat (3) @(negedge clk);
    btn = '0;
    waitYp(8);
    checkOutput("grant_ack", {6'd0, btn_ack}, 8'h01);
    checkOutput("grant_pend", {7'd0, req_pending}, 8'd1);
    checkOutput("grant_lockout", {7'd0, lockout}, 8'd0);
    clr_count = 1'b0;
    @(negedge clk);
    checkOutput("serve_yp", {7'd0, yp}, 8'd0);
    checkOutput("serve_ack", {6'd0, btn_ack}, 8'd0);
    checkOutput("serve_pend", {7'd0, req_pending}, 8'd0);

    pressButtons(2'b10, 4);
    checkOutput("serve_press_ack", {6'd0, btn_ack}, 8'd0);
    checkOutput("serve_press_pend", {7'd0, req_pending}, 8'd0);

    // Walk counter table; the final row also moves SERVE into hold-off.
    for (int i = 0; i < 8; i++) applyStimulus(walk_tbl[i]);
    inc_count = 1'b0;
    runHoldoff(2'b10, 1, 1'b1);
    checkOutput("regrant_pend", {7'd0, req_pending}, 8'd1);

    // Hold-off with no press returns to READY.
    clr_count = 1'b0;
    @(negedge clk);
    checkOutput("serve2_yp", {7'd0, yp}, 8'd0);
    enterHoldoff();
    runHoldoff(2'b00, 0, 1'b0);
    checkOutput("ready_ack", {6'd0, btn_ack}, 8'd0);
    checkOutput("ready_pend", {7'd0, req_pending}, 8'd0);

    // Press landing exactly on the hold-off expiry clk is granted.
    pressButtons(2'b01, 0);
    waitYp(8);
    clr_count = 1'b0;
    @(negedge clk);
    enterHoldoff();
    runHoldoff(2'b01, 9, 1'b1);

    // Simultaneous presses in GRANT, then reset mid-operation.
    pressButtons(2'b11, 2);
    checkOutput("both_ack", {6'd0, btn_ack}, 8'h03);
    #2 reset = 1'b1;
    #1 checkAllZero("midreset");
    @(negedge clk);
    reset = 1'b0;
    checkTicks(8, "tick_restart");
    checkOutput("post_reset_yp", {7'd0, yp}, 8'd0);
    checkOutput("post_reset_ack", {6'd0, btn_ack}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
